// File: rtl/vga_hex_overlay_pkg.sv
// Shared constants, types and helpers for the hex-value video overlay.
// Used by the overlay top and by the reusable 8x8 hex font ROM.
package vga_hex_overlay_pkg;

    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 8;
    localparam int NUM_DIGITS = 8;
    localparam int BOX_W      = GLYPH_W * NUM_DIGITS;
    localparam int POS_W      = 11;

    typedef logic [POS_W-1:0] pos_t;

    localparam pos_t POS_MAX = '1;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        rgb_t rgb;
    } video_t;

    // Counter increment that sticks at the top value instead of wrapping.
    function automatic pos_t sat_inc(input pos_t p);
        return (p == POS_MAX) ? p : p + 1'b1;
    endfunction

    // Digit 0 is the leftmost digit, i.e. the most significant nibble.
    function automatic logic [3:0] digit_nibble(input logic [31:0] v, input logic [2:0] digit);
        logic [31:0] shifted;
        shifted = v << {digit, 2'b00};
        return shifted[31:28];
    endfunction

endpackage

// File: rtl/vga_hex_overlay_font8x8_hex.sv
// Combinational 8x8 font ROM for the hex digits 0-9 and A-F.
// Row 0 is the top scan line; bit 7 of each row is the leftmost pixel.
module font8x8_hex
    import vga_hex_overlay_pkg::*;
(
    input  logic [3:0]         nibble,
    input  logic [2:0]         row,
    output logic [GLYPH_W-1:0] bits
);

    logic [63:0] glyph;

    // Each glyph packs its 8 rows top-to-bottom, row 0 in the top byte.
    always_comb begin
        glyph = 64'h0;
        case (nibble)
            4'h0: glyph = 64'h3C666E7666663C00;
            4'h1: glyph = 64'h1838181818187E00;
            4'h2: glyph = 64'h3C66060C30607E00;
            4'h3: glyph = 64'h3C66061C06663C00;
            4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
            4'h5: glyph = 64'h7E607C0606663C00;
            4'h6: glyph = 64'h3C66607C66663C00;
            4'h7: glyph = 64'h7E660C1818181800;
            4'h8: glyph = 64'h3C66663C66663C00;
            4'h9: glyph = 64'h3C66663E06663C00;
            4'hA: glyph = 64'h183C667E66666600;
            4'hB: glyph = 64'h7C66667C66667C00;
            4'hC: glyph = 64'h3C66606060663C00;
            4'hD: glyph = 64'h786C6666666C7800;
            4'hE: glyph = 64'h7E60607860607E00;
            4'hF: glyph = 64'h7E60607860606000;
        endcase
    end

    assign bits = glyph[{~row, 3'b000} +: GLYPH_W];

endmodule

// File: rtl/vga_hex_overlay.sv
// Paints a 32-bit value as 8 hex digits over the VGA pixel stream with a fixed 2-cycle latency.
// Build option VGA_HEX_OVERLAY_TRANSPARENT_EN: glyph background shows the incoming picture.
module vga_hex_overlay
    import vga_hex_overlay_pkg::*;
#(
    parameter int unsigned C_x0        = 8,
    parameter int unsigned C_y0        = 8,
    parameter logic        C_vsync_pol = 1'b0,
    parameter logic [23:0] C_fg        = 24'hFFFFFF,
    parameter logic [23:0] C_bg        = 24'h000080
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  in_red,
    input  logic [7:0]  in_green,
    input  logic [7:0]  in_blue,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_blank,
    output logic [7:0]  out_red,
    output logic [7:0]  out_green,
    output logic [7:0]  out_blue,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_blank
);

    localparam pos_t X0      = pos_t'(C_x0);
    localparam pos_t Y0      = pos_t'(C_y0);
    localparam pos_t BOX_W_P = pos_t'(BOX_W);
    localparam pos_t BOX_H_P = pos_t'(GLYPH_H);

`ifdef VGA_HEX_OVERLAY_TRANSPARENT_EN
    localparam logic TRANSPARENT = 1'b1;
`else
    localparam logic TRANSPARENT = 1'b0;
`endif

    pos_t        x_q;
    pos_t        y_q;
    logic        blank_q;
    logic        vsync_q;
    logic        frame_valid;
    logic [31:0] value_q;
    logic        vsync_edge;
    logic        line_end;

    assign vsync_edge = (vsync_q != C_vsync_pol) && (in_vsync == C_vsync_pol);
    assign line_end   = ~blank_q & in_blank;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            blank_q     <= 1'b0;
            vsync_q     <= 1'b0;
            frame_valid <= 1'b0;
            value_q     <= '0;
        end else begin
            blank_q <= in_blank;
            vsync_q <= in_vsync;
            x_q     <= in_blank ? '0 : sat_inc(x_q);
            // Frame start outranks a coincident end-of-line; value is only sampled here.
            if (vsync_edge) begin
                y_q         <= '0;
                value_q     <= value;
                frame_valid <= 1'b1;
            end else if (line_end) begin
                y_q <= sat_inc(y_q);
            end
        end
    end

    pos_t                x_off;
    pos_t                y_off;
    logic                box_hit;
    logic [3:0]          nibble;
    logic [GLYPH_W-1:0]  glyph_row;
    video_t              video_in;

    assign x_off    = x_q - X0;
    assign y_off    = y_q - Y0;
    assign box_hit  = ~in_blank & frame_valid
                    & (x_q >= X0) & (x_off < BOX_W_P)
                    & (y_q >= Y0) & (y_off < BOX_H_P);
    assign nibble   = digit_nibble(value_q, x_off[5:3]);
    assign video_in = {in_hsync, in_vsync, in_blank, in_red, in_green, in_blue};

    font8x8_hex u_font (
        .nibble (nibble),
        .row    (y_off[2:0]),
        .bits   (glyph_row)
    );

    logic               hit_s1;
    logic [2:0]         col_s1;
    logic [GLYPH_W-1:0] glyph_s1;
    video_t             video_s1;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hit_s1   <= 1'b0;
            col_s1   <= '0;
            glyph_s1 <= '0;
            video_s1 <= '0;
        end else begin
            hit_s1   <= box_hit;
            col_s1   <= x_off[2:0];
            glyph_s1 <= glyph_row;
            video_s1 <= video_in;
        end
    end

    rgb_t rgb_next;

    // NOTE: rgb_next gets its default first, so no path through this block can infer a latch.
    always_comb begin
        rgb_next = video_s1.rgb;
        if (hit_s1) begin
            // Leftmost pixel is bit 7, so column c reads bit ~c.
            if (glyph_s1[~col_s1]) begin
                rgb_next = rgb_t'(C_fg);
            end else if (!TRANSPARENT) begin
                rgb_next = rgb_t'(C_bg);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_blank <= 1'b1;
        end else begin
            out_red   <= rgb_next.red;
            out_green <= rgb_next.green;
            out_blue  <= rgb_next.blue;
            out_hsync <= video_s1.hsync;
            out_vsync <= video_s1.vsync;
            out_blank <= video_s1.blank;
        end
    end

endmodule

// File: tb/tb_vga_hex_overlay.sv
// Self-checking bench for vga_hex_overlay on a reduced VGA-like raster (active-low syncs).
// A spec-level model checks every pixel; directed table vectors check hand-computed glyph pixels.
module tb_vga_hex_overlay;

    localparam int V_ACT = 24;
    localparam int V_TOT = 30;
    localparam int H_MAX = 96;
    localparam logic [23:0] FG   = 24'hFFFFFF;
    localparam logic [23:0] GREY = 24'h202020;
`ifdef VGA_HEX_OVERLAY_TRANSPARENT_EN
    localparam bit          TB_TRANSPARENT = 1'b1;
    localparam logic [23:0] EXP_BG         = GREY;
`else
    localparam bit          TB_TRANSPARENT = 1'b0;
    localparam logic [23:0] EXP_BG         = 24'h000080;
`endif

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic [7:0]  in_red, in_green, in_blue;
    logic        in_hsync, in_vsync, in_blank;
    logic [7:0]  out_red, out_green, out_blue;
    logic        out_hsync, out_vsync, out_blank;

    vga_hex_overlay dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .value     (value),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_blank  (in_blank),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .out_blank (out_blank)
    );

    always #5 clk_pixel = ~clk_pixel;

    logic [63:0] font [16] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C66607C66663C00, 64'h7E660C1818181800,
        64'h3C66663C66663C00, 64'h3C66663E06663C00, 64'h183C667E66666600, 64'h7C66667C66667C00,
        64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607860607E00, 64'h7E60607860606000
    };

    typedef struct {
        logic        act;
        int          line;
        int          px;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
        logic        fv;
        logic [31:0] val;
    } hist_t;

    typedef struct {
        int          line;
        int          px;
        logic [23:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          sync_err = 0;
    int          rgb_err  = 0;
    int          h_act    = H_MAX;
    int          cur_line = 0;
    int          cur_px   = 0;
    int          hist_cnt = 0;
    int          mon_hold = 0;
    logic        mon_en   = 1'b0;
    logic        m_fv     = 1'b0;
    logic        m_prev_vs = 1'b0;
    logic [31:0] m_val    = '0;
    hist_t       h0, h1, h2;
    logic [23:0] fb [V_ACT][H_MAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected output colour for one input pixel, straight from the overlay definition.
    function automatic logic [23:0] exp_rgb(input hist_t h);
        int          dx;
        int          dy;
        logic [3:0]  nib;
        logic [63:0] g;
        logic [7:0]  row_bits;
        if (!(h.act && h.fv)) return h.rgb;
        dx = h.px - 8;
        dy = h.line - 8;
        if (dx < 0 || dx > 63 || dy < 0 || dy > 7) return h.rgb;
        nib      = h.val[31 - 4 * (dx / 8) -: 4];
        g        = font[nib];
        row_bits = g[63 - 8 * dy -: 8];
        if (row_bits[7 - (dx % 8)]) return FG;
        return TB_TRANSPARENT ? h.rgb : EXP_BG;
    endfunction

    // Each negedge sees the outputs for the inputs driven two clock edges earlier.
    always @(negedge clk_pixel) begin
        h2 = h1;
        h1 = h0;
        h0.act  = ~in_blank;
        h0.line = cur_line;
        h0.px   = cur_px;
        h0.hs   = in_hsync;
        h0.vs   = in_vsync;
        h0.bl   = in_blank;
        h0.rgb  = {in_red, in_green, in_blue};
        h0.fv   = m_fv;
        h0.val  = m_val;
        if (hist_cnt < 3) hist_cnt++;
        if (mon_en && hist_cnt >= 3) begin
            if ({out_hsync, out_vsync, out_blank} !== {h2.hs, h2.vs, h2.bl}) sync_err++;
            if ({out_red, out_green, out_blue} !== exp_rgb(h2)) begin
                if (rgb_err == 0)
                    $display("  first rgb difference: line %0d px %0d got %h want %h",
                             h2.line, h2.px, {out_red, out_green, out_blue}, exp_rgb(h2));
                rgb_err++;
            end
            if (h2.act) fb[h2.line][h2.px] = {out_red, out_green, out_blue};
        end
    end

    task automatic drive_cycle(input int line, input int px, input logic [23:0] rgb,
                               input logic [31:0] val, input logic rst);
        logic act;
        @(posedge clk_pixel);
        #1;
        act      = (line < V_ACT) && (px < h_act);
        reset    = rst;
        value    = val;
        in_blank = ~act;
        in_hsync = ~((px >= h_act + 4) && (px < h_act + 12));
        in_vsync = ~((line >= V_ACT + 2) && (line < V_ACT + 4));
        {in_red, in_green, in_blue} = act ? rgb : 24'h0;
        cur_line = line;
        cur_px   = px;
        if (rst) begin
            m_fv      = 1'b0;
            m_prev_vs = 1'b0;
            mon_hold  = 3;
        end else begin
            if (m_prev_vs && !in_vsync) begin
                m_fv  = 1'b1;
                m_val = val;
            end
            m_prev_vs = in_vsync;
        end
        if (mon_hold > 0) begin
            mon_en = 1'b0;
            mon_hold--;
        end else begin
            mon_en = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input int hact, input logic [31:0] val0,
                             input logic [31:0] val1, input int change_line,
                             input logic [23:0] rgb, input bit pattern, input int reset_line);
        logic [23:0] pix;
        logic [7:0]  pb;
        logic [7:0]  lb;
        logic        rst;
        h_act    = hact;
        sync_err = 0;
        rgb_err  = 0;
        for (int line = 0; line < V_TOT; line++) begin
            for (int px = 0; px < hact + 16; px++) begin
                pb  = px[7:0];
                lb  = line[7:0];
                pix = pattern ? {pb, lb, 8'h5A} : rgb;
                rst = (line == reset_line) && (px >= 20) && (px <= 22);
                drive_cycle(line, px, pix, (line >= change_line) ? val1 : val0, rst);
                if (line == reset_line && px >= 21 && px <= 23) begin
                    @(negedge clk_pixel);
                    check($sformatf("%s_reset_out_px%0d", tag, px),
                          32'({out_red, out_green, out_blue, out_hsync, out_vsync, out_blank}),
                          32'({24'h0, 3'b001}));
                end
            end
        end
        check({tag, "_sync_errors"}, sync_err, 0);
        check({tag, "_rgb_errors"}, rgb_err, 0);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{8, 7,  GREY};
        vecs[1]  = '{8, 8,  EXP_BG};
        vecs[2]  = '{8, 10, FG};
        vecs[3]  = '{8, 16, EXP_BG};
        vecs[4]  = '{8, 19, FG};
        vecs[5]  = '{8, 24, EXP_BG};
        vecs[6]  = '{8, 42, EXP_BG};
        vecs[7]  = '{8, 43, FG};
        vecs[8]  = '{8, 49, FG};
        vecs[9]  = '{8, 64, EXP_BG};
        vecs[10] = '{8, 65, FG};
        vecs[11] = '{8, 71, EXP_BG};
        vecs[12] = '{8, 72, GREY};
        vecs[13] = '{9, 9,  FG};
        vecs[14] = '{15, 12, EXP_BG};
        vecs[15] = '{16, 12, GREY};

        reset = 1'b1;
        value = '0;
        {in_red, in_green, in_blue} = '0;
        in_hsync = 1'b1;
        in_vsync = 1'b1;
        in_blank = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive_cycle(V_TOT - 1, H_MAX, 24'h0, 32'h0, 1'b1);
            if (i == 1) begin
                @(negedge clk_pixel);
                check("initial_reset_out",
                      32'({out_red, out_green, out_blue, out_hsync, out_vsync, out_blank}),
                      32'({24'h0, 3'b001}));
            end
        end
        for (int i = 0; i < 4; i++) drive_cycle(V_TOT - 1, H_MAX, 24'h0, 32'h0, 1'b0);

        // Frame A: no vsync seen yet, pure 2-cycle pass-through of a coordinate pattern.
        run_frame("A", H_MAX, 32'h0, 32'h0123ABCF, 20, 24'h0, 1'b1, -1);
        check("A_box_untouched", 32'(fb[8][12]), 32'h000C085A);

        // Frame B: draws "0123ABCF" over grey.
        run_frame("B", H_MAX, 32'h0123ABCF, 32'h11111111, 20, GREY, 1'b0, -1);
        foreach (vecs[i])
            check($sformatf("B_line%0d_px%0d", vecs[i].line, vecs[i].px),
                  32'(fb[vecs[i].line][vecs[i].px]), 32'(vecs[i].exp));

        // Frame C: value changes at line 10, display keeps the latched '1's.
        run_frame("C", H_MAX, 32'h11111111, 32'h22222222, 10, GREY, 1'b0, -1);
        check("C_line9_px11",  32'(fb[9][11]),  32'(FG));
        check("C_line11_px11", 32'(fb[11][11]), 32'(FG));
        check("C_line11_px13", 32'(fb[11][13]), 32'(EXP_BG));

        // Frame D: new value appears from the next vsync edge.
        run_frame("D", H_MAX, 32'h22222222, 32'h22222222, 0, GREY, 1'b0, -1);
        check("D_line11_px11", 32'(fb[11][11]), 32'(EXP_BG));
        check("D_line11_px13", 32'(fb[11][13]), 32'(FG));

        // Frame E: reset inside the box rows suppresses the overlay until the next vsync.
        run_frame("E", H_MAX, 32'h22222222, 32'h22222222, 0, GREY, 1'b0, 10);
        check("E_line9_px9",   32'(fb[9][9]),   32'(FG));
        check("E_line12_px11", 32'(fb[12][11]), 32'(GREY));

        run_frame("F", H_MAX, 32'h22222222, 32'h22222222, 0, GREY, 1'b0, -1);
        check("F_line8_px10", 32'(fb[8][10]), 32'(FG));

        // Frame G: 40-pixel lines clip the box; no wrap onto the next line.
        run_frame("G", 40, 32'h22222222, 32'h22222222, 0, GREY, 1'b0, -1);
        check("G_line8_px36", 32'(fb[8][36]), 32'(FG));
        check("G_line8_px39", 32'(fb[8][39]), 32'(EXP_BG));
        check("G_line9_px0",  32'(fb[9][0]),  32'(GREY));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
